rv32i_memarbiter: RTL
=====================

Name: rv32i_memArbiter

Overview:
- Arbitrates the single data port of syncDualPortRam between two requesters.
  - Port A: pipeline memory stage (high priority).
  - Port B: loader/debug DMA requester (low priority, lockable).
- Sits between memTop/loader and the RAM data port.
- Registers the winning command onto memif_*, then returns read data to the owning requester two cycles after grant.
- Starvation counter guarantees B forward progress.

Parameters:
- MAX_STARVE, 4: consecutive cycles B may be pending-and-denied before it is forced to win; legal range 1..15.
- CNT_W, 4: width of the starvation counter.

Ports:
- clk  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-low reset (0 = reset asserted)
- a_req  in  1  A request; held stable until a_gnt
- a_we  in  1  A write (1) / read (0)
- a_be  in  4  A byte enables
- a_addr  in  30  A word address [31:2]
- a_wdata  in  32  A write data (already lane-shifted)
- a_gnt  out  1  A granted this cycle (combinational)
- a_rvalid  out  1  A read data valid
- a_rdata  out  32  A read data
- b_req, b_we, b_be, b_addr, b_wdata  in  1/1/4/30/32  B request, same rules as A
- b_lock  in  1  B holds ownership across consecutive grants while high
- b_gnt  out  1  B granted this cycle (combinational)
- b_rvalid  out  1  B read data valid
- b_rdata  out  32  B read data
- memif_we  out  1  RAM write enable (registered)
- memif_be  out  4  RAM byte enables (registered)
- memif_addr  out  30  RAM word address (registered)
- memif_wdata  out  32  RAM write data (registered)
- memif_rdata  in  32  RAM read data, valid 1 cycle after command cycle
- busy  out  1  a read is in flight

Behaviour:
- Reset (reset=0, async): state=IDLE, starve_cnt=0, read-tag pipe cleared, all outputs 0. Reset mid-transfer drops in-flight reads; no rvalid is issued after release.
- FSM states: IDLE, A_OWN, B_OWN, B_LOCKED. State records the owner of the last grant.
- Grant rules, evaluated combinationally each cycle:
  - B_LOCKED and b_req: B wins; A is denied.
  - Else starve_cnt==MAX_STARVE and b_req: B wins.
  - Else a_req: A wins.
  - Else b_req: B wins.
  - Else no grant.
- At most one gnt per cycle; a_gnt & b_gnt never both 1.
- State transitions:
  - Grant to A → A_OWN.
  - Grant to B with b_lock=1 → B_LOCKED.
  - Grant to B with b_lock=0 → B_OWN.
  - No grant → IDLE.
  - B_LOCKED exits when b_lock=0 or b_req=0 in a cycle.
- starve_cnt:
  - Increments (saturating at MAX_STARVE) when b_req=1 and b_gnt=0.
  - Clears on b_gnt or when b_req=0.
- Command register: on the grant cycle N, the winner's we/be/addr/wdata are latched into memif_* and driven during N+1.
  - With no grant, memif_we is forced 0 next cycle; addr/be/wdata hold their last values.
  - memif_be for reads = requester be (unused by RAM).
- Read return: a read granted in cycle N gives {rvalid, rdata=memif_rdata} at the owning port in cycle N+2 for one cycle. Writes produce no rvalid.
  - 2-deep tag pipe {valid, owner} tracks order.
  - Back-to-back reads deliver one rvalid per cycle, in grant order.
  - Non-owner rdata = 0.
- busy = OR of tag-pipe valid bits.
- Simultaneous a_req & b_req with starve_cnt<MAX_STARVE and not locked: A wins.
- A requester dropping req without gnt is legal (request withdrawn). Dropping req after gnt has no effect.

Test Plan:
- Reset/idle: assert reset=0 mid-read, release → all outputs 0, no rvalid follows; memif_we=0.
- A read: a_req, a_addr=0x100, RAM word 0xDEADBEEF → a_gnt cycle N, memif_addr=0x100 at N+1, a_rvalid=1 with a_rdata=0xDEADBEEF at N+2, b_rvalid=0.
- Priority/starvation: a_req and b_req held continuously, MAX_STARVE=4 → A granted 4 cycles, B granted 5th, pattern repeats; never both gnt.
- Lock: b_lock=1, b_req for 3 writes while a_req=1 → 3 consecutive b_gnt, RAM sees 3 writes, A granted the cycle after b_lock falls.
- Interleaved reads: A read @0x10, B read @0x20, A read @0x30 in consecutive cycles → rvalid order A,B,A at N+2..N+4 with correct data per port.
- Write/read ordering: A write 0x55AA00FF be=4'b1111 @0x40 then A read @0x40 next cycle → a_rdata=0x55AA00FF.

Source files
------------

// File: rtl/rv32i_memarbiter.sv
// rtl/rv32i_memarbiter.sv - two-requester arbiter for the RAM data port with lock, starvation guard and read return
module rv32i_memarbiter #(
    parameter int MAX_STARVE = 4,
    parameter int CNT_W      = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        a_req,
    input  logic        a_we,
    input  logic [3:0]  a_be,
    input  logic [29:0] a_addr,
    input  logic [31:0] a_wdata,
    output logic        a_gnt,
    output logic        a_rvalid,
    output logic [31:0] a_rdata,
    input  logic        b_req,
    input  logic        b_we,
    input  logic [3:0]  b_be,
    input  logic [29:0] b_addr,
    input  logic [31:0] b_wdata,
    input  logic        b_lock,
    output logic        b_gnt,
    output logic        b_rvalid,
    output logic [31:0] b_rdata,
    output logic        memif_we,
    output logic [3:0]  memif_be,
    output logic [29:0] memif_addr,
    output logic [31:0] memif_wdata,
    input  logic [31:0] memif_rdata,
    output logic        busy
);

    localparam logic [CNT_W-1:0] STARVE_LIMIT = CNT_W'(MAX_STARVE);

    typedef enum logic [1:0] {
        IDLE,
        A_OWN,
        B_OWN,
        B_LOCKED
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   starve_cnt;
    logic               tag0_v;
    logic               tag0_b;
    logic               tag1_v;
    logic               tag1_b;
    logic               b_win;
    logic               a_win;

    // A keeps priority unless B holds the lock or has waited too long.
    always_comb begin
        b_win = b_req && ((state == B_LOCKED) || (starve_cnt == STARVE_LIMIT) || !a_req);
        a_win = a_req && !b_win;
    end

    assign a_gnt = a_win;
    assign b_gnt = b_win;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            starve_cnt  <= '0;
            tag0_v      <= 1'b0;
            tag0_b      <= 1'b0;
            tag1_v      <= 1'b0;
            tag1_b      <= 1'b0;
            memif_we    <= 1'b0;
            memif_be    <= '0;
            memif_addr  <= '0;
            memif_wdata <= '0;
        end else begin
            if (b_win) begin
                state       <= b_lock ? B_LOCKED : B_OWN;
                memif_we    <= b_we;
                memif_be    <= b_be;
                memif_addr  <= b_addr;
                memif_wdata <= b_wdata;
            end else if (a_win) begin
                state       <= A_OWN;
                memif_we    <= a_we;
                memif_be    <= a_be;
                memif_addr  <= a_addr;
                memif_wdata <= a_wdata;
            end else begin
                state       <= IDLE;
                memif_we    <= 1'b0;
            end

            if (b_req && !b_win) begin
                if (starve_cnt != STARVE_LIMIT)
                    starve_cnt <= starve_cnt + 1'b1;
            end else begin
                starve_cnt <= '0;
            end

            // Stage 0 covers the command cycle, stage 1 the cycle RAM data is valid.
            tag0_v <= (a_win && !a_we) || (b_win && !b_we);
            tag0_b <= b_win;
            tag1_v <= tag0_v;
            tag1_b <= tag0_b;
        end
    end

    assign a_rvalid = tag1_v && !tag1_b;
    assign b_rvalid = tag1_v && tag1_b;
    assign a_rdata  = a_rvalid ? memif_rdata : 32'h0;
    assign b_rdata  = b_rvalid ? memif_rdata : 32'h0;
    assign busy     = tag0_v || tag1_v;

endmodule
